// File: rtl/branch_sequencer.sv
// Branch/jump sequencer: decodes control-transfer ops, runs the ALU compare handshake, resolves next PC.
// Optional BRANCH_STATS_EN adds taken_cnt / resolved_cnt statistics outputs.
module branch_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic [31:0] pc,
  input  logic [31:0] rs_val,
  output logic [2:0]  BranchSelect,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic        LineSelection,
  output logic [31:0] pc_next,
  output logic        pc_load,
  output logic        flush,
  output logic        timeout_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] resolved_cnt
`endif
);

  localparam logic [2:0] SEL_NONE = 3'b101;
  localparam logic [7:0] WAIT_LAST = 8'd254;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESOLVE, LOAD} state_t;

  typedef struct packed {
    logic [2:0]  sel;
    logic        isJ;
    logic        isJr;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] pc;
    logic [31:0] rsVal;
  } instr_t;

  state_t      state, nextState;
  instr_t      lat;
  logic [7:0]  waitCnt;
  logic [31:0] pcNextReg;
  logic        takenReg;

  logic [2:0]  decSel;
  logic        decJ, decJr;
  logic [31:0] pcPlus4, resolvePc;
  logic        resolveTaken;

  always_comb begin
    decSel = SEL_NONE;
    decJ   = 1'b0;
    decJr  = 1'b0;
    case (op)
      6'h00: if (funct == 6'h08) begin decSel = 3'b000; decJr = 1'b1; end
      6'h02: begin decSel = 3'b000; decJ = 1'b1; end
      6'h04: decSel = 3'b001;
      6'h05: decSel = 3'b010;
      6'h07: decSel = 3'b011;
      6'h06: decSel = 3'b100;
      default: ;
    endcase
  end

  // Resolution works only from latched fields; live inputs are ignored after acceptance.
  always_comb begin
    pcPlus4      = lat.pc + 32'd4;
    resolveTaken = 1'b1;
    if (lat.isJr)     resolvePc = lat.rsVal;
    else if (lat.isJ) resolvePc = {pcPlus4[31:28], lat.target, 2'b00};
    else begin
      resolveTaken = LineSelection;
      resolvePc    = LineSelection ? pcPlus4 + {{14{lat.imm[15]}}, lat.imm, 2'b00} : pcPlus4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (instr_valid) begin
                 if (decJ || decJr)         nextState = RESOLVE;
                 else if (decSel != SEL_NONE) nextState = ISSUE;
               end
      ISSUE:   nextState = alu_done ? RESOLVE : WAIT;
      WAIT:    if (alu_done)                nextState = RESOLVE;
               else if (waitCnt == WAIT_LAST) nextState = IDLE;
      RESOLVE: nextState = LOAD;
      LOAD:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = (state == IDLE);
    alu_start    = (state == ISSUE);
    pc_load      = (state == LOAD);
    flush        = (state == LOAD) && takenReg;
    BranchSelect = (state == IDLE || state == LOAD) ? SEL_NONE : lat.sel;
    pc_next      = pcNextReg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lat         <= '0;
      lat.sel     <= SEL_NONE;
      waitCnt     <= '0;
      pcNextReg   <= '0;
      takenReg    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid)
        lat <= '{sel: decSel, isJ: decJ, isJr: decJr, imm: imm, target: target, pc: pc, rsVal: rs_val};
      waitCnt <= (state == WAIT) ? waitCnt + 8'd1 : 8'd0;
      if (state == WAIT && !alu_done && waitCnt == WAIT_LAST)
        timeout_err <= 1'b1;
      if (state == RESOLVE) begin
        pcNextReg <= resolvePc;
        takenReg  <= resolveTaken;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      taken_cnt    <= '0;
      resolved_cnt <= '0;
    end else if (state == LOAD) begin
      resolved_cnt <= resolved_cnt + 16'd1;
      if (takenReg) taken_cnt <= taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: hand-computed PCs, handshake timing, timeout and reset abort.
module tb_branch_sequencer;
  logic        clock = 1'b0;
  logic        reset, instr_valid, alu_done, LineSelection;
  logic        instr_ready, alu_start, pc_load, flush, timeout_err;
  logic [5:0]  op, funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] pc, rs_val, pc_next;
  logic [2:0]  BranchSelect;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt, resolved_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic sawLoad;

  branch_sequencer dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .funct(funct), .imm(imm), .target(target), .pc(pc), .rs_val(rs_val),
    .BranchSelect(BranchSelect), .alu_start(alu_start), .alu_done(alu_done),
    .LineSelection(LineSelection), .pc_next(pc_next), .pc_load(pc_load), .flush(flush),
    .timeout_err(timeout_err)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .resolved_cnt(resolved_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [5:0] o, input logic [5:0] f, input logic [15:0] i,
                         input logic [25:0] t, input logic [31:0] p, input logic [31:0] r);
    instr_valid = 1'b1; op = o; funct = f; imm = i; target = t; pc = p; rs_val = r;
  endtask

  task automatic scramble();
    instr_valid = 1'b0; op = 6'h05; funct = 6'h08; imm = 16'h7FFF;
    target = 26'h3FFFFFF; pc = 32'hDEADBEEF; rs_val = 32'hCAFEF00D;
  endtask

  // Conditional branch with alu_done already high in ISSUE: accept, ISSUE, RESOLVE, LOAD.
  task automatic runCond(input string tag, input logic [5:0] o, input logic [31:0] p,
                         input logic [15:0] i, input logic ls, input logic [31:0] expPc);
    present(o, 6'h00, i, 26'h0, p, 32'h0);
    LineSelection = ls; alu_done = 1'b1;
    tick(); scramble();
    tick(); alu_done = 1'b0;
    tick();
    check({tag, ".pc_load"}, pc_load, 1'b1);
    check({tag, ".flush"}, flush, ls);
    check({tag, ".pc_next"}, pc_next, expPc);
    tick();
  endtask

  initial begin
    reset = 1'b1; alu_done = 1'b0; LineSelection = 1'b0;
    scramble();
    tick(); tick();
    check("rst.ready", instr_ready, 1'b1);
    check("rst.sel", BranchSelect, 3'b101);
    check("rst.alu_start", alu_start, 1'b0);
    check("rst.pc_load", pc_load, 1'b0);
    check("rst.flush", flush, 1'b0);
    check("rst.pc_next", pc_next, 32'h0);
    check("rst.timeout", timeout_err, 1'b0);
    reset = 1'b0;
    tick();

    // beq taken, alu_done two cycles after alu_start
    present(6'h04, 6'h00, 16'h0004, 26'h0, 32'h100, 32'h0);
    LineSelection = 1'b1;
    tick(); scramble();
    check("beq.alu_start", alu_start, 1'b1);
    check("beq.sel_issue", BranchSelect, 3'b001);
    check("beq.ready", instr_ready, 1'b0);
    tick();
    check("beq.alu_start_once", alu_start, 1'b0);
    tick(); alu_done = 1'b1;
    tick(); alu_done = 1'b0;
    check("beq.sel_resolve", BranchSelect, 3'b001);
    check("beq.no_early_load", pc_load, 1'b0);
    tick();
    check("beq.pc_load", pc_load, 1'b1);
    check("beq.flush", flush, 1'b1);
    check("beq.pc_next", pc_next, 32'h114);
    check("beq.sel_load", BranchSelect, 3'b101);
    tick();
    check("beq.load_once", pc_load, 1'b0);
    check("beq.flush_once", flush, 1'b0);
    check("beq.hold", pc_next, 32'h114);
    check("beq.ready_back", instr_ready, 1'b1);

    // bne not taken, alu_done honored in ISSUE
    present(6'h05, 6'h00, 16'hFFFF, 26'h0, 32'h100, 32'h0);
    LineSelection = 1'b0; alu_done = 1'b1;
    tick(); scramble();
    check("bne.sel", BranchSelect, 3'b010);
    tick(); alu_done = 1'b0;
    check("bne.resolve_no_start", alu_start, 1'b0);
    tick();
    check("bne.pc_load", pc_load, 1'b1);
    check("bne.flush", flush, 1'b0);
    check("bne.pc_next", pc_next, 32'h104);
    tick();

    // j: two cycles accept -> pc_load, no ALU request
    present(6'h02, 6'h00, 16'h0, 26'h0000010, 32'h40000000, 32'h0);
    LineSelection = 1'b0;
    tick(); scramble();
    check("j.no_alu", alu_start, 1'b0);
    check("j.sel", BranchSelect, 3'b000);
    tick();
    check("j.pc_load", pc_load, 1'b1);
    check("j.flush", flush, 1'b1);
    check("j.pc_next", pc_next, 32'h40000040);
    tick();

    // jr
    present(6'h00, 6'h08, 16'h0, 26'h0, 32'h00000800, 32'h12345678);
    tick(); scramble();
    tick();
    check("jr.pc_load", pc_load, 1'b1);
    check("jr.pc_next", pc_next, 32'h12345678);
    tick();

    // non-branch opcode stays IDLE
    present(6'h3F, 6'h00, 16'h0, 26'h0, 32'h0, 32'h0);
    tick(); scramble();
    check("none.ready", instr_ready, 1'b1);
    check("none.sel", BranchSelect, 3'b101);
    tick();
    check("none.no_load", pc_load, 1'b0);
    check("none.hold", pc_next, 32'h12345678);

    // blt with no alu_done: timeout after 255 WAIT cycles
    present(6'h06, 6'h00, 16'h0010, 26'h0, 32'h200, 32'h0);
    tick(); scramble();
    check("blt.sel", BranchSelect, 3'b100);
    tick();
    sawLoad = 1'b0;
    for (int k = 0; k < 254; k++) begin
      tick();
      if (pc_load) sawLoad = 1'b1;
    end
    check("blt.still_wait", instr_ready, 1'b0);
    check("blt.no_early_err", timeout_err, 1'b0);
    tick();
    check("blt.timeout", timeout_err, 1'b1);
    check("blt.ready", instr_ready, 1'b1);
    check("blt.sel_idle", BranchSelect, 3'b101);
    check("blt.no_load", pc_load | sawLoad, 1'b0);
    tick();
    check("blt.no_load_late", pc_load, 1'b0);

    // reset during WAIT aborts; timeout_err sticky until then
    present(6'h07, 6'h00, 16'h0001, 26'h0, 32'h300, 32'h0);
    tick(); scramble();
    tick(); tick();
    check("rstwait.sticky", timeout_err, 1'b1);
    check("rstwait.sel", BranchSelect, 3'b011);
    reset = 1'b1; alu_done = 1'b1;
    tick();
    reset = 1'b0; alu_done = 1'b0;
    check("rstwait.ready", instr_ready, 1'b1);
    check("rstwait.sel_idle", BranchSelect, 3'b101);
    check("rstwait.pc_load", pc_load, 1'b0);
    check("rstwait.flush", flush, 1'b0);
    check("rstwait.timeout", timeout_err, 1'b0);
    check("rstwait.pc_next", pc_next, 32'h0);
    tick();
    check("rstwait.no_load_after", pc_load, 1'b0);

    // 3 taken + 2 not-taken conditionals
    runCond("c1", 6'h04, 32'h1000, 16'h0002, 1'b1, 32'h100C);
    runCond("c2", 6'h07, 32'h1000, 16'hFFFE, 1'b1, 32'h0FFC);
    runCond("c3", 6'h06, 32'h1000, 16'h0002, 1'b0, 32'h1004);
    runCond("c4", 6'h05, 32'hFFFFFFFC, 16'h0001, 1'b1, 32'h00000004);
    runCond("c5", 6'h04, 32'h2000, 16'h8000, 1'b0, 32'h2004);
`ifdef BRANCH_STATS_EN
    check("stats.taken", taken_cnt, 16'd3);
    check("stats.resolved", resolved_cnt, 16'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
